// File: rtl/sr_mul_pkg.sv
// Shared types for the schoolRISCV RV32M multiply unit.
package sr_mul_pkg;

   typedef enum logic [1:0] {
      MUL    = 2'b00,
      MULH   = 2'b01,
      MULHSU = 2'b10,
      MULHU  = 2'b11
   } mul_op_t;

   localparam int unsigned MUL_N_MAX = 8;

   typedef struct packed {
      logic        valid;
      logic [4:0]  rd;
      logic [31:0] data;
   } mul_stage_t;

endpackage

// File: rtl/sr_mul_delay_line.sv
// N-deep valid/payload shift register. Flush clears in-flight valids; payloads only
// advance behind a valid bit so the last stage holds its last completed value.
module sr_mul_delay_line
   import sr_mul_pkg::*;
#(
   parameter int unsigned N = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       flush,
   input  mul_stage_t inStage,
   output mul_stage_t outStage,
   output logic       busy
);

   mul_stage_t stageQ [N];
   mul_stage_t stageD [N];

   always_comb begin
      // A new issue is never killed by a flush in the same cycle.
      stageD[0]       = stageQ[0];
      stageD[0].valid = 1'b0;
      if (inStage.valid) stageD[0] = inStage;
      for (int k = 1; k < int'(N); k++) begin
         stageD[k]       = stageQ[k];
         stageD[k].valid = 1'b0;
         if (stageQ[k-1].valid && !flush) stageD[k] = stageQ[k-1];
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int k = 0; k < int'(N); k++) stageQ[k] <= '0;
      end else begin
         for (int k = 0; k < int'(N); k++) stageQ[k] <= stageD[k];
      end
   end

   // The output stage is being presented, so it no longer counts as in flight.
   always_comb begin
      busy = 1'b0;
      for (int k = 0; k < int'(N) - 1; k++) busy = busy | stageQ[k].valid;
   end

   assign outStage = stageQ[N-1];

endmodule

// File: rtl/sr_mul_unit.sv
// Fixed-latency pipelined RV32M multiplier (MUL/MULH/MULHSU/MULHU) for schoolRISCV.
// Result and destination tag emerge N cycles after start.
module sr_mul_unit
   import sr_mul_pkg::*;
#(
   parameter int unsigned N = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [1:0]  op,
   input  logic [31:0] srcA,
   input  logic [31:0] srcB,
   input  logic [4:0]  rdIn,
   input  logic        flush,
   output logic        done,
   output logic [31:0] result,
   output logic [4:0]  rdOut,
   output logic        busy
);

   if (N < 1 || N > MUL_N_MAX) begin : gBadN
      $error("sr_mul_unit: N must be in 1..%0d", MUL_N_MAX);
   end

   logic        signA;
   logic        signB;
   logic [63:0] aExt;
   logic [63:0] bExt;
   logic [63:0] prod;
   logic [31:0] resData;
   mul_stage_t  inStage;
   mul_stage_t  outStage;

   always_comb begin
      signA = 1'b1;
      signB = 1'b1;
      unique case (mul_op_t'(op))
         MUL:    begin signA = 1'b1; signB = 1'b1; end
         MULH:   begin signA = 1'b1; signB = 1'b1; end
         MULHSU: begin signA = 1'b1; signB = 1'b0; end
         MULHU:  begin signA = 1'b0; signB = 1'b0; end
         default: ;
      endcase
   end

   // Extending straight to 64 bits gives the 66-bit signed product truncated to 64.
   assign aExt    = {{32{signA & srcA[31]}}, srcA};
   assign bExt    = {{32{signB & srcB[31]}}, srcB};
   assign prod    = aExt * bExt;
   assign resData = (mul_op_t'(op) == MUL) ? prod[31:0] : prod[63:32];

   always_comb begin
      inStage       = '0;
      inStage.valid = start;
      inStage.rd    = rdIn;
      inStage.data  = resData;
   end

   sr_mul_delay_line #(
      .N(N)
   ) delayLine (
      .clk      (clk),
      .rst      (rst),
      .flush    (flush),
      .inStage  (inStage),
      .outStage (outStage),
      .busy     (busy)
   );

   assign done   = outStage.valid;
   assign result = outStage.data;
   assign rdOut  = outStage.rd;

endmodule

// File: tb/tb_sr_mul_unit.sv
// Bench for sr_mul_unit: four instances (N=1..4) share stimulus and are checked every
// cycle against a completion-schedule model, plus directed constant checks.
module tb_sr_mul_unit;
   import sr_mul_pkg::*;

   localparam int NDUT = 4;
   localparam int MAXC = 2048;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic        flush;
   logic [1:0]  op;
   logic [31:0] srcA;
   logic [31:0] srcB;
   logic [4:0]  rdIn;

   logic        doneW [NDUT];
   logic [31:0] resW  [NDUT];
   logic [4:0]  rdW   [NDUT];
   logic        busyW [NDUT];

   always #5 clk = ~clk;

   for (genvar g = 0; g < NDUT; g++) begin : gDut
      sr_mul_unit #(
         .N(g + 1)
      ) dut (
         .clk    (clk),
         .rst    (rst),
         .start  (start),
         .op     (op),
         .srcA   (srcA),
         .srcB   (srcB),
         .rdIn   (rdIn),
         .flush  (flush),
         .done   (doneW[g]),
         .result (resW[g]),
         .rdOut  (rdW[g]),
         .busy   (busyW[g])
      );
   end

   // Model: per instance, which cycle each result is due and what it must be.
   bit          schedV  [NDUT][MAXC];
   logic [31:0] schedR  [NDUT][MAXC];
   logic [4:0]  schedRd [NDUT][MAXC];
   logic [31:0] lastR   [NDUT];
   logic [4:0]  lastRd  [NDUT];
   int          cyc = 0;
   int          errors = 0;
   int          checks = 0;

   function automatic logic [31:0] refMul(logic [1:0] o, logic [31:0] a, logic [31:0] b);
      longint sa;
      longint sb;
      longint p;
      sa = (o == 2'b11) ? longint'({32'b0, a}) : longint'($signed(a));
      sb = o[1] ? longint'({32'b0, b}) : longint'($signed(b));
      p  = sa * sb;
      return (o == 2'b00) ? p[31:0] : p[63:32];
   endfunction

   task automatic check(string tag, int d, logic [31:0] got, logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s N=%0d cycle=%0d: got %h expected %h", tag, d + 1, cyc, got, exp);
      end
   endtask

   task automatic checkAll();
      logic expBusy;
      for (int d = 0; d < NDUT; d++) begin
         if (schedV[d][cyc]) begin
            lastR[d]  = schedR[d][cyc];
            lastRd[d] = schedRd[d][cyc];
         end
         expBusy = 1'b0;
         for (int c = cyc + 1; c <= cyc + MUL_N_MAX; c++) expBusy = expBusy | schedV[d][c];
         check("done", d, 32'(doneW[d]), 32'(schedV[d][cyc]));
         check("busy", d, 32'(busyW[d]), 32'(expBusy));
         check("result", d, resW[d], lastR[d]);
         check("rdOut", d, 32'(rdW[d]), 32'(lastRd[d]));
      end
   endtask

   task automatic tick();
      @(posedge clk);
      cyc++;
      if (rst) begin
         for (int d = 0; d < NDUT; d++) begin
            if (flush)
               for (int c = cyc; c <= cyc + MUL_N_MAX; c++) schedV[d][c] = 1'b0;
            if (start) begin
               schedV[d][cyc + d]  = 1'b1;
               schedR[d][cyc + d]  = refMul(op, srcA, srcB);
               schedRd[d][cyc + d] = rdIn;
            end
         end
      end
      #1;
      checkAll();
   endtask

   task automatic issue(logic [1:0] o, logic [31:0] a, logic [31:0] b, logic [4:0] r);
      start = 1'b1;
      op    = o;
      srcA  = a;
      srcB  = b;
      rdIn  = r;
   endtask

   task automatic idle();
      start = 1'b0;
      flush = 1'b0;
   endtask

   // Asynchronous reset asserted mid-cycle, held across one edge, released mid-cycle.
   task automatic doReset();
      #2 rst = 1'b0;
      #1;
      for (int d = 0; d < NDUT; d++) begin
         for (int c = cyc; c <= cyc + MUL_N_MAX; c++) schedV[d][c] = 1'b0;
         lastR[d]  = '0;
         lastRd[d] = '0;
      end
      checkAll();
      tick();
      #2 rst = 1'b1;
   endtask

   initial begin
      rst   = 1'b1;
      start = 1'b0;
      flush = 1'b0;
      op    = 2'b00;
      srcA  = '0;
      srcB  = '0;
      rdIn  = '0;
      for (int d = 0; d < NDUT; d++) begin
         lastR[d]  = '0;
         lastRd[d] = '0;
      end
      #2 rst = 1'b0;
      #1 checkAll();
      tick();
      #2 rst = 1'b1;
      tick();

      // Reset one cycle after issue: the operation must never complete.
      issue(MUL, 32'd7, 32'd6, 5'd5);
      tick();
      idle();
      doReset();
      repeat (10) tick();
      check("rst_result", 2, resW[2], 32'h0);
      check("rst_busy", 2, 32'(busyW[2]), 32'h0);

      // Basic latency on N=2.
      issue(MUL, 32'd7, 32'd6, 5'd3);
      tick();
      idle();
      check("lat_busy", 1, 32'(busyW[1]), 32'h1);
      tick();
      check("lat_done", 1, 32'(doneW[1]), 32'h1);
      check("lat_res", 1, resW[1], 32'd42);
      check("lat_rd", 1, 32'(rdW[1]), 32'd3);
      repeat (5) tick();

      // Signedness, N=2.
      issue(MUL, 32'hFFFF_FFFF, 32'h2, 5'd1);
      tick();
      issue(MULH, 32'hFFFF_FFFF, 32'h2, 5'd2);
      tick();
      check("sgn_mul", 1, resW[1], 32'hFFFF_FFFE);
      issue(MULHSU, 32'hFFFF_FFFF, 32'h2, 5'd3);
      tick();
      check("sgn_mulh", 1, resW[1], 32'hFFFF_FFFF);
      issue(MULHU, 32'hFFFF_FFFF, 32'h2, 5'd4);
      tick();
      check("sgn_mulhsu", 1, resW[1], 32'hFFFF_FFFF);
      idle();
      tick();
      check("sgn_mulhu", 1, resW[1], 32'h0000_0001);
      repeat (5) tick();

      // Back-to-back, N=4.
      issue(MUL, 32'd3, 32'd5, 5'd1);
      tick();
      issue(MUL, 32'hFFFF_FFFE, 32'd4, 5'd2);
      tick();
      issue(MULHU, 32'h0001_0000, 32'h0001_0000, 5'd4);
      tick();
      idle();
      tick();
      check("b2b_res0", 3, resW[3], 32'd15);
      check("b2b_rd0", 3, 32'(rdW[3]), 32'd1);
      tick();
      check("b2b_res1", 3, resW[3], 32'hFFFF_FFF8);
      check("b2b_rd1", 3, 32'(rdW[3]), 32'd2);
      tick();
      check("b2b_res2", 3, resW[3], 32'h0000_0001);
      check("b2b_rd2", 3, 32'(rdW[3]), 32'd4);
      repeat (5) tick();

      // Flush with simultaneous start, N=3.
      issue(MUL, 32'd5, 32'd5, 5'd1);
      tick();
      issue(MUL, 32'd9, 32'd9, 5'd2);
      flush = 1'b1;
      tick();
      idle();
      tick();
      check("fl_nodone", 2, 32'(doneW[2]), 32'h0);
      tick();
      check("fl_done", 2, 32'(doneW[2]), 32'h1);
      check("fl_res", 2, resW[2], 32'd81);
      check("fl_rd", 2, 32'(rdW[2]), 32'd2);
      repeat (5) tick();

      // Wrap corner on N=1.
      issue(MUL, 32'h8000_0000, 32'h8000_0000, 5'd7);
      tick();
      check("n1_mul", 0, resW[0], 32'h0);
      check("n1_done", 0, 32'(doneW[0]), 32'h1);
      issue(MULH, 32'h8000_0000, 32'h8000_0000, 5'd8);
      tick();
      check("n1_mulh", 0, resW[0], 32'h4000_0000);
      idle();
      tick();

      // Random traffic with occasional flush and one reset.
      for (int i = 0; i < 500; i++) begin
         start = ($urandom_range(0, 9) < 7);
         flush = ($urandom_range(0, 19) == 0);
         op    = 2'($urandom_range(0, 3));
         srcA  = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
         srcB  = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom;
         rdIn  = 5'($urandom_range(0, 31));
         tick();
         if (i == 250) begin
            idle();
            doReset();
         end
      end
      idle();
      repeat (10) tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
